grid_io_bank_cfg: RTL and testbench



---
 rtl/grid_io_bank_cfg.sv | 102 ++++++++++
 tb/tb_grid_io_bank_cfg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/grid_io_bank_cfg.sv
// Parametrised IO bank tile: NUM_IO pad channels configured by one chain segment,
// with a shadow stage so pads only change on an accepted commit.
module grid_io_bank_cfg #(
    parameter int NUM_IO   = 4,
    parameter int CFG_BITS = 2
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              isol_n,
    input  logic              ccff_shift_en,
    input  logic              ccff_head,
    output logic              ccff_tail,
    input  logic              cfg_commit,
    input  logic [NUM_IO-1:0] gfpga_pad_io_soc_in,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_out,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir,
    input  logic [NUM_IO-1:0] io_outpad,
    output logic [NUM_IO-1:0] io_inpad,
    output logic              cfg_loaded,
    output logic              cfg_error,
    output logic [$clog2(NUM_IO*CFG_BITS+1)-1:0] cfg_count
);
    localparam int TOTAL_BITS = NUM_IO * CFG_BITS;
    localparam int CNT_W      = $clog2(TOTAL_BITS + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(TOTAL_BITS);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOADING,
        ST_FULL
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [TOTAL_BITS-1:0] r_sr;
    logic [TOTAL_BITS-1:0] r_shd;
    logic                  r_loaded;
    logic                  r_error;
    logic                  w_accept;
    logic                  w_reject;

    always_comb begin
        w_accept    = cfg_commit && (r_state == ST_FULL);
        w_reject    = cfg_commit && (r_state != ST_FULL);
        w_count_nxt = r_count;
        // A shift in the same cycle as an accepted commit is the first bit of the next frame.
        if (w_accept) begin
            w_count_nxt = ccff_shift_en ? CNT_W'(1) : '0;
        end else if (ccff_shift_en && (r_count != FULL_COUNT)) begin
            w_count_nxt = r_count + 1'b1;
        end
        if (w_count_nxt == '0) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_count_nxt == FULL_COUNT) begin
            w_state_nxt = ST_FULL;
        end else begin
            w_state_nxt = ST_LOADING;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state  <= ST_EMPTY;
            r_count  <= '0;
            r_sr     <= '0;
            r_shd    <= '0;
            r_loaded <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let shd capture the pre-shift sr in a commit+shift cycle.
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (ccff_shift_en) begin
                r_sr <= {r_sr[TOTAL_BITS-2:0], ccff_head};
            end
            if (w_accept) begin
                r_shd    <= r_sr;
                r_loaded <= 1'b1;
            end
            if (w_reject) begin
                r_error <= 1'b1;
            end
        end
    end

    assign ccff_tail  = r_sr[TOTAL_BITS-1];
    assign cfg_loaded = r_loaded;
    assign cfg_error  = r_error;
    assign cfg_count  = r_count;

    for (genvar k = 0; k < NUM_IO; k++) begin : g_chan
        logic w_dir;
        logic w_inv;
        assign w_dir = r_shd[k*CFG_BITS];
        assign w_inv = r_shd[k*CFG_BITS+1];
        assign gfpga_pad_io_soc_dir[k] = isol_n & w_dir;
        assign gfpga_pad_io_soc_out[k] = isol_n & w_dir & (io_outpad[k] ^ w_inv);
        assign io_inpad[k]             = isol_n & ~w_dir & (gfpga_pad_io_soc_in[k] ^ w_inv);
    end
endmodule

// File: tb/tb_grid_io_bank_cfg.sv
// Directed self-checking bench for grid_io_bank_cfg (NUM_IO=4, CFG_BITS=2).
module tb_grid_io_bank_cfg;
    logic       prog_clk = 1'b0;
    logic       prog_reset;
    logic       isol_n;
    logic       ccff_shift_en;
    logic       ccff_head;
    logic       ccff_tail;
    logic       cfg_commit;
    logic [3:0] soc_in;
    logic [3:0] soc_out;
    logic [3:0] soc_dir;
    logic [3:0] io_outpad;
    logic [3:0] io_inpad;
    logic       cfg_loaded;
    logic       cfg_error;
    logic [3:0] cfg_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       isol_n;
        logic [3:0] soc_in;
        logic [3:0] outpad;
        logic [3:0] exp_dir;
        logic [3:0] exp_out;
        logic [3:0] exp_inpad;
    } vec_t;

    vec_t vecs[5];

    // Frames are written first-shifted bit at [7], so after 8 shifts sr[7:0] equals the frame.
    localparam logic [7:0] FRAME_A = 8'b0100_0111;  // dir=1011 inv=0001
    localparam logic [7:0] FRAME_B = 8'b0101_0101;  // dir=1111 inv=0000
    localparam logic [7:0] FRAME_C = 8'b1100_1001;  // dir=1001 inv=1010

    grid_io_bank_cfg #(.NUM_IO(4), .CFG_BITS(2)) dut (
        .prog_clk             (prog_clk),
        .prog_reset           (prog_reset),
        .isol_n               (isol_n),
        .ccff_shift_en        (ccff_shift_en),
        .ccff_head            (ccff_head),
        .ccff_tail            (ccff_tail),
        .cfg_commit           (cfg_commit),
        .gfpga_pad_io_soc_in  (soc_in),
        .gfpga_pad_io_soc_out (soc_out),
        .gfpga_pad_io_soc_dir (soc_dir),
        .io_outpad            (io_outpad),
        .io_inpad             (io_inpad),
        .cfg_loaded           (cfg_loaded),
        .cfg_error            (cfg_error),
        .cfg_count            (cfg_count)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        ccff_shift_en = 1'b1;
        ccff_head     = b;
        tick();
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
    endtask

    task automatic shift_frame(input logic [7:0] f);
        for (int i = 0; i < 8; i++) shift_bit(f[7-i]);
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic do_reset();
        prog_reset = 1'b1;
        tick();
        prog_reset = 1'b0;
    endtask

    task automatic check_pads(input string name, input logic [3:0] d, input logic [3:0] o,
                              input logic [3:0] ip);
        check({name, ".dir"}, 32'(soc_dir), 32'(d));
        check({name, ".out"}, 32'(soc_out), 32'(o));
        check({name, ".inpad"}, 32'(io_inpad), 32'(ip));
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'b1010, 4'b0011, 4'b1011, 4'b0010, 4'b0000};
        vecs[1] = '{1'b1, 4'b0100, 4'b1111, 4'b1011, 4'b1010, 4'b0100};
        vecs[2] = '{1'b1, 4'b0000, 4'b0000, 4'b1011, 4'b0001, 4'b0000};
        vecs[3] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
        vecs[4] = '{1'b1, 4'b1111, 4'b0001, 4'b1011, 4'b0000, 4'b0100};

        prog_reset = 1'b1; isol_n = 1'b1; ccff_shift_en = 1'b0; ccff_head = 1'b0;
        cfg_commit = 1'b0; soc_in = 4'b1010; io_outpad = 4'b0000;
        do_reset();
        tick();
        check("rst.count", 32'(cfg_count), 0);
        check("rst.loaded", 32'(cfg_loaded), 0);
        check("rst.error", 32'(cfg_error), 0);
        check("rst.tail", 32'(ccff_tail), 0);
        check_pads("rst", 4'b0000, 4'b0000, 4'b1010);

        // Frame A: count climbs one per shift, no pad change before commit.
        for (int i = 0; i < 8; i++) begin
            shift_bit(FRAME_A[7-i]);
            check($sformatf("loadA.count%0d", i + 1), 32'(cfg_count), 32'(i + 1));
        end
        check_pads("preA", 4'b0000, 4'b0000, 4'b1010);
        commit();
        check("A.loaded", 32'(cfg_loaded), 1);
        check("A.count", 32'(cfg_count), 0);
        check("A.error", 32'(cfg_error), 0);

        for (int i = 0; i < 5; i++) begin
            isol_n    = vecs[i].isol_n;
            soc_in    = vecs[i].soc_in;
            io_outpad = vecs[i].outpad;
            #1;
            check_pads($sformatf("vecA%0d", i), vecs[i].exp_dir, vecs[i].exp_out, vecs[i].exp_inpad);
        end

        // Reload with B: pads must hold frame A's configuration every cycle.
        isol_n = 1'b1; soc_in = 4'b1010; io_outpad = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            shift_bit(FRAME_B[7-i]);
            check_pads($sformatf("stable%0d", i), 4'b1011, 4'b0010, 4'b0000);
        end
        commit();

        // Isolation with dir=1111 and recovery without reload.
        io_outpad = 4'b0110; soc_in = 4'b1111; isol_n = 1'b0;
        #1;
        check_pads("isol", 4'b0000, 4'b0000, 4'b0000);
        isol_n = 1'b1;
        #1;
        check_pads("unisol", 4'b1111, 4'b0110, 4'b0000);

        // Early commit rejected, then the completed frame is accepted.
        for (int i = 0; i < 5; i++) shift_bit(FRAME_C[7-i]);
        commit();
        check("early.error", 32'(cfg_error), 1);
        check("early.count", 32'(cfg_count), 5);
        check("early.dir", 32'(soc_dir), 32'(4'b1111));
        for (int i = 5; i < 8; i++) shift_bit(FRAME_C[7-i]);
        check("C.full", 32'(cfg_count), 8);
        commit();
        check("C.count", 32'(cfg_count), 0);
        check("C.error", 32'(cfg_error), 1);
        soc_in = 4'b0000; io_outpad = 4'b0000;
        #1;
        check_pads("C", 4'b1001, 4'b1000, 4'b0010);

        // Tail shows sr[7]; commit with shift in FULL latches the pre-shift frame.
        for (int i = 0; i < 7; i++) shift_bit(FRAME_A[7-i]);
        check("tail.before", 32'(ccff_tail), 1);
        shift_bit(FRAME_A[0]);
        check("tail.first", 32'(ccff_tail), 0);
        cfg_commit = 1'b1;
        shift_bit(1'b1);
        cfg_commit = 1'b0;
        check("cs.count", 32'(cfg_count), 1);
        check("cs.tail", 32'(ccff_tail), 1);
        check("cs.dir", 32'(soc_dir), 32'(4'b1011));

        for (int i = 0; i < 9; i++) shift_bit(1'b0);
        check("sat.count", 32'(cfg_count), 8);

        // Reset mid-frame with shift and commit asserted.
        shift_bit(1'b1);
        ccff_shift_en = 1'b1; cfg_commit = 1'b1; ccff_head = 1'b1; soc_in = 4'b0110;
        do_reset();
        ccff_shift_en = 1'b0; cfg_commit = 1'b0;
        check("rst2.count", 32'(cfg_count), 0);
        check("rst2.error", 32'(cfg_error), 0);
        check("rst2.loaded", 32'(cfg_loaded), 0);
        check("rst2.tail", 32'(ccff_tail), 0);
        check_pads("rst2", 4'b0000, 4'b0000, 4'b0110);

        commit();
        check("empty.error", 32'(cfg_error), 1);
        check("empty.count", 32'(cfg_count), 0);
        check("empty.loaded", 32'(cfg_loaded), 0);

        do_reset();
        shift_bit(1'b1);
        cfg_commit = 1'b1;
        shift_bit(1'b1);
        cfg_commit = 1'b0;
        check("lcs.error", 32'(cfg_error), 1);
        check("lcs.count", 32'(cfg_count), 2);
        check("lcs.dir", 32'(soc_dir), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
